// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared addresses, entry type and event encoding for the fetch front end
package instr_fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam logic [31:0] RESET_ADDR_DEF = 32'd0;
    localparam logic [31:0] ILLOP_ADDR_DEF = 32'd97;
    localparam logic [31:0] XADR_ADDR_DEF  = 32'd98;
    localparam int unsigned DEPTH_DEF      = 100;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Listed in decreasing priority; EV_NONE means a normal push may happen.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_ILLOP,
        EV_REDIRECT,
        EV_IRQ,
        EV_RANGE
    } fetch_event_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM, decode and trap signals between fetch and the rest of the core
interface instr_fetch_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_id;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illop;
    logic        irq;
    logic        xp_valid;
    logic [31:0] xp_pc;

    modport master (
        output imem_pc, out_valid, out_instr, out_pc, xp_valid, xp_pc,
        input  imem_id, out_ready, redirect_valid, redirect_pc, illop, irq
    );

    modport slave (
        input  imem_pc, out_valid, out_instr, out_pc, xp_valid, xp_pc,
        output imem_id, out_ready, redirect_valid, redirect_pc, illop, irq
    );
endinterface

// File: rtl/instr_fetch_buf.sv
// rtl/instr_fetch_buf.sv - two-entry {pc,instr} queue with push, pop and flush
module instr_fetch_buf
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output fetch_entry_t second,
    output logic [1:0]   count
);

    // The caller only pushes when a slot is free (or freed by pop) and only pops a non-empty queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            head   <= '0;
            second <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= wr_entry;
                    else               second <= wr_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= second;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= wr_entry;
                    end else begin
                        head   <= second;
                        second <= wr_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, control-transfer priority and trap capture feeding decode
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
    parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
)(
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [31:0]  fpc, fpc_next;
    logic         xp_valid_next;
    logic [31:0]  xp_pc_next;
    logic         pop, push, flush, irq_ok;
    logic [1:0]   count;
    fetch_entry_t head, second, wr_entry;
    fetch_event_e ev;

    assign bus.imem_pc   = fpc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    assign pop      = bus.out_valid & bus.out_ready;
    assign irq_ok   = bus.irq && (fpc != XADR_ADDR) && (fpc != ILLOP_ADDR);
    assign wr_entry = '{pc: fpc, instr: bus.imem_id};

    always_comb begin
        ev = EV_NONE;
        if (bus.illop)               ev = EV_ILLOP;
        else if (bus.redirect_valid) ev = EV_REDIRECT;
        else if (irq_ok)             ev = EV_IRQ;
        else if (fpc >= DEPTH_W)     ev = EV_RANGE;
    end

    always_comb begin
        fpc_next      = fpc;
        xp_valid_next = 1'b0;
        xp_pc_next    = bus.xp_pc;
        flush         = (ev != EV_NONE);
        push          = 1'b0;
        case (ev)
            EV_ILLOP: begin
                fpc_next      = ILLOP_ADDR;
                xp_valid_next = 1'b1;
                xp_pc_next    = head.pc + 32'd1;
            end
            EV_REDIRECT: fpc_next = bus.redirect_pc;
            EV_IRQ: begin
                fpc_next      = XADR_ADDR;
                xp_valid_next = 1'b1;
                // Resume point is the oldest instruction decode has not taken.
                if (bus.out_valid && !pop)        xp_pc_next = head.pc;
                else if (count == 2'd2 && pop)    xp_pc_next = second.pc;
                else                              xp_pc_next = fpc;
            end
            EV_RANGE: begin
                fpc_next      = ILLOP_ADDR;
                xp_valid_next = 1'b1;
                xp_pc_next    = fpc;
            end
            default: begin
                push = (count != 2'd2) || pop;
                if (push) fpc_next = fpc + 32'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc          <= RESET_ADDR;
            bus.xp_valid <= 1'b0;
            bus.xp_pc    <= 32'd0;
        end else begin
            fpc          <= fpc_next;
            bus.xp_valid <= xp_valid_next;
            bus.xp_pc    <= xp_pc_next;
        end
    end

    instr_fetch_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .second   (second),
        .count    (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed checks of fetch latency, stall, redirect and trap behaviour
module tb_instr_fetch;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return (pc * 32'h9E3779B1) ^ 32'h0BAD_F00D;
    endfunction

    assign bus.imem_id = rom(bus.imem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.illop = 1'b0;
        bus.irq = 1'b0;
        #3;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);
        check("rst_instr", bus.out_instr, 32'd0);
        check("rst_xp_valid", 32'(bus.xp_valid), 32'd0);
        check("rst_xp_pc", bus.xp_pc, 32'd0);
        check("rst_imem_pc", bus.imem_pc, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Stall: queue fills with pc 0 and 1, fetch PC parks at 2.
        step();
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_pc", bus.out_pc, 32'd0);
        check("first_instr", bus.out_instr, rom(32'd0));
        for (int i = 0; i < 4; i++) step();
        check("stall_pc", bus.out_pc, 32'd0);
        check("stall_instr", bus.out_instr, rom(32'd0));
        check("stall_fpc", bus.imem_pc, 32'd2);
        bus.out_ready = 1'b1;
        step();
        check("drain_pc1", bus.out_pc, 32'd1);
        step();
        check("drain_pc2", bus.out_pc, 32'd2);
        check("drain_instr2", bus.out_instr, rom(32'd2));
        step();
        check("drain_pc3", bus.out_pc, 32'd3);

        // Redirect while popping pc 3; queued pc 4 is dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd20;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_flush", 32'(bus.out_valid), 32'd0);
        check("redir_fpc", bus.imem_pc, 32'd20);
        check("redir_no_xp", 32'(bus.xp_valid), 32'd0);
        step();
        check("redir_valid", 32'(bus.out_valid), 32'd1);
        check("redir_pc20", bus.out_pc, 32'd20);
        check("redir_instr20", bus.out_instr, rom(32'd20));
        step();
        check("redir_pc21", bus.out_pc, 32'd21);

        // Illegal op with head pc 7.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd7;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("ill_head7", bus.out_pc, 32'd7);
        bus.illop = 1'b1;
        step();
        bus.illop = 1'b0;
        check("ill_xp_valid", 32'(bus.xp_valid), 32'd1);
        check("ill_xp_pc", bus.xp_pc, 32'd8);
        check("ill_flush", 32'(bus.out_valid), 32'd0);
        step();
        check("ill_xp_drop", 32'(bus.xp_valid), 32'd0);
        check("ill_vec_pc", bus.out_pc, 32'd97);
        check("ill_vec_valid", 32'(bus.out_valid), 32'd1);

        // Interrupt with head pc 11 held by decode.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd11;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("irq_head11", bus.out_pc, 32'd11);
        bus.out_ready = 1'b0;
        bus.irq = 1'b1;
        step();
        check("irq_xp_valid", 32'(bus.xp_valid), 32'd1);
        check("irq_xp_pc", bus.xp_pc, 32'd11);
        check("irq_fpc", bus.imem_pc, 32'd98);
        check("irq_flush", 32'(bus.out_valid), 32'd0);
        step();
        check("irq_no_retrap", 32'(bus.xp_valid), 32'd0);
        check("irq_vec_pc", bus.out_pc, 32'd98);
        check("irq_vec_fpc", bus.imem_pc, 32'd99);
        bus.irq = 1'b0;
        bus.out_ready = 1'b1;

        // Redirect out of range: trapped one cycle later.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'd150;
        step();
        bus.redirect_valid = 1'b0;
        check("oor_fpc", bus.imem_pc, 32'd150);
        check("oor_empty", 32'(bus.out_valid), 32'd0);
        check("oor_no_xp_yet", 32'(bus.xp_valid), 32'd0);
        step();
        check("oor_xp_valid", 32'(bus.xp_valid), 32'd1);
        check("oor_xp_pc", bus.xp_pc, 32'd150);
        check("oor_still_empty", 32'(bus.out_valid), 32'd0);
        check("oor_vec_fpc", bus.imem_pc, 32'd97);
        step();
        check("oor_vec_pc", bus.out_pc, 32'd97);
        check("oor_vec_valid", 32'(bus.out_valid), 32'd1);

        // Async reset in a stalled state.
        bus.out_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_pc", bus.out_pc, 32'd0);
        check("async_rst_fpc", bus.imem_pc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch front end that reads the combinational instruction ROM: drives the word-indexed PC, takes the instruction word back in the same cycle, and queues {pc, instr} pairs in a 2-entry buffer toward decode over a valid/ready handshake.
- Handles reset vector, branch/jump redirect, illegal-op trap, interrupt trap and out-of-range PC, flushing queued instructions on every control transfer.

Parameters:
- RESET_ADDR, 32'd0, PC after reset (program selector entry).
- ILLOP_ADDR, 32'd97, trap vector for illegal op or out-of-range PC.
- XADR_ADDR, 32'd98, interrupt vector.
- DEPTH, 100, instruction words implemented; valid PC range is 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_pc  output  32  word address to instruction ROM.
- imem_id  input  32  instruction word for imem_pc, valid same cycle.
- out_valid  output  1  buffer head holds an instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  PC of head instruction.
- redirect_valid  input  1  taken branch/JMP; load redirect_pc.
- redirect_pc  input  32  branch/JMP target, word address.
- illop  input  1  decode found illegal opcode.
- irq  input  1  level interrupt request.
- xp_valid  output  1  one-cycle pulse: trap taken, xp_pc valid.
- xp_pc  output  32  PC of first unexecuted instruction at trap (saved to XP).

Behaviour:
- Reset (async assert, sync release): fpc=RESET_ADDR, count=0, out_valid=0, out_instr=0, out_pc=0, xp_valid=0, xp_pc=0. imem_pc=fpc at all times.
- Buffer: 2-entry FIFO of {pc,instr}. pop = out_valid & out_ready. push allowed when count<2 or pop in the same cycle. Push stores {fpc, imem_id}, then fpc<=fpc+1. Arithmetic is 32-bit modulo 2^32.
- Latency: first rising edge after reset release pushes word RESET_ADDR; out_valid=1 from the next cycle. Back-to-back throughput is 1 instruction/cycle with out_ready held high.
- Stall: count==2 and no pop -> no push, fpc holds, head stable. A stalled head must never change while out_valid & !out_ready.
- Control events, evaluated per cycle in priority order (illop, redirect_valid, irq, out-of-range, normal push). The first true one wins. Every control event flushes (count<=0) and suppresses the push that cycle. A pop in the same cycle is still counted as consumed.
  - illop: fpc<=ILLOP_ADDR; xp_pc<=out_pc+1; xp_valid<=1.
  - redirect_valid: fpc<=redirect_pc; no xp pulse.
  - irq (and no higher event): fpc<=XADR_ADDR; xp_pc<=head pc if out_valid & !pop, else second entry pc if count==2 & pop, else fpc; xp_valid<=1. irq is ignored while fpc is in [XADR_ADDR, XADR_ADDR] or [ILLOP_ADDR, ILLOP_ADDR], so a trap handler is not re-interrupted at its entry.
  - Out-of-range: fpc>=DEPTH -> no push; fpc<=ILLOP_ADDR; xp_pc<=fpc; xp_valid<=1.
- xp_valid deasserts the cycle after the pulse. Simultaneous illop and irq: illop taken, irq re-evaluated next cycle.
- Redirect to an out-of-range target: accepted, then trapped by the range check the following cycle.
- Reset mid-stall or mid-trap: all state cleared immediately. The buffer contents are discarded.

Decomposition:
- Shared risc_constants.vh: RESET/ILLOP/XADR address defaults and instruction width, shared with the ROM and decode.
- One sub-module, fetch_buf: 2-entry {pc,instr} FIFO with push/pop/flush and count.
- The top holds fpc, the event priority logic and the xp capture.

Test Plan:
- Reset release, out_ready=1 -> cycle 1 out_valid=1, out_pc=0, out_instr=ROM[0]; out_pc then 1, 2, 3 on consecutive cycles.
- out_ready=0 for 5 cycles after reset -> count saturates at 2, fpc=2, head stays pc 0. Raise out_ready -> pcs 0, 1, 2 delivered with no gap or duplicate.
- Pop pc 3 with redirect_valid=1, redirect_pc=20 -> queued pc 4 flushed; next out_pc=20, then 21; xp_valid stays 0.
- illop while head pc=7 -> xp_valid pulse with xp_pc=8; next delivered out_pc=97.
- irq with head pc=11 not popped -> xp_pc=11, next out_pc=98; irq held high does not re-trap at 98.
- redirect_pc=150 -> no instruction from 150 delivered; xp_pc=150, xp_valid pulse, next out_pc=97. Asserting reset in a stalled state clears out_valid asynchronously.
